// File: rtl/bnn_pkg.sv
// bnn_pkg: shared sizing constants and loader state type for the BNN output stage
package bnn_pkg;
  localparam int NUM_INPUTS = 196;
  localparam int NUM_CLASSES = 10;
  localparam int BYTE_W = 8;
  localparam int BYTES_PER_ROW = (NUM_INPUTS + BYTE_W - 1) / BYTE_W;
  localparam int ROWS = NUM_CLASSES + 1;
  typedef enum logic {LOAD, FULL} loader_state_t;
endpackage

// File: rtl/bnn_row_register.sv
// bnn_row_register: one NUM_INPUTS-bit row written one byte per enabled edge
// Ports: clock, reset (async active-low), we_i write enable, byte_idx_i byte slot,
//        byte_i data byte, row_o stored row.
module bnn_row_register
  import bnn_pkg::*;
#(
  parameter int NUM_INPUTS = bnn_pkg::NUM_INPUTS,
  parameter int BYTE_W = bnn_pkg::BYTE_W,
  parameter int IDX_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      byte_idx_i,
  input  logic [BYTE_W-1:0]     byte_i,
  output logic [NUM_INPUTS-1:0] row_o
);
  localparam int BPR = (NUM_INPUTS + BYTE_W - 1) / BYTE_W;
  for (genvar k = 0; k < BPR; k++) begin : g_byte
    localparam int LO = k * BYTE_W;
    // the last slot is narrower; its upper byte bits have nowhere to go
    localparam int W = (NUM_INPUTS - LO < BYTE_W) ? NUM_INPUTS - LO : BYTE_W;
    logic [W-1:0] q;
    always_ff @(posedge clock or negedge reset)
      if (!reset) q <= '0;
      else if (we_i && byte_idx_i == IDX_W'(k)) q <= byte_i[W-1:0];
    assign row_o[LO+W-1:LO] = q;
  end
endmodule

// File: rtl/bnn_frame_loader.sv
// bnn_frame_loader: byte stream to activation vector + weight rows, held until acked
// Ports: clock, reset (async active-low); in_byte/in_valid/in_ready byte stream;
//        frame_abort sync restart; vec_out row 0; weights_out rows 1..NUM_CLASSES;
//        out_valid frame held; out_ack consumer took the frame.
module bnn_frame_loader
  import bnn_pkg::*;
#(
  parameter int NUM_INPUTS = bnn_pkg::NUM_INPUTS,
  parameter int NUM_CLASSES = bnn_pkg::NUM_CLASSES,
  parameter int BYTE_W = bnn_pkg::BYTE_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BYTE_W-1:0]     in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  frame_abort,
  output logic [NUM_INPUTS-1:0] vec_out,
  output logic [NUM_INPUTS-1:0] weights_out [NUM_CLASSES-1:0],
  output logic                  out_valid,
  input  logic                  out_ack
);
  localparam int BPR = (NUM_INPUTS + BYTE_W - 1) / BYTE_W;
  localparam int NROWS = NUM_CLASSES + 1;
  localparam int BW = $clog2(BPR);
  localparam int RW = $clog2(NROWS);
  loader_state_t state_q;
  logic [BW-1:0] byte_q;
  logic [RW-1:0] row_q;
  logic accept, last_byte, last_row;
  logic [NUM_INPUTS-1:0] rows [NROWS];
  assign in_ready = state_q == LOAD;
  assign out_valid = state_q == FULL;
  assign accept = in_ready && in_valid && !frame_abort;
  assign last_byte = byte_q == BW'(BPR - 1);
  assign last_row = row_q == RW'(NROWS - 1);
  // counters wrap to 0 on the final byte, so FULL is entered with them already cleared
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= LOAD;
      byte_q <= '0;
      row_q <= '0;
    end else if (frame_abort) begin
      state_q <= LOAD;
      byte_q <= '0;
      row_q <= '0;
    end else if (state_q == FULL) begin
      if (out_ack) state_q <= LOAD;
    end else if (in_valid) begin
      byte_q <= last_byte ? '0 : byte_q + 1'b1;
      if (last_byte) row_q <= last_row ? '0 : row_q + 1'b1;
      if (last_byte && last_row) state_q <= FULL;
    end
  for (genvar r = 0; r < NROWS; r++) begin : g_row
    bnn_row_register #(.NUM_INPUTS(NUM_INPUTS), .BYTE_W(BYTE_W), .IDX_W(BW)) u_row (
      .clock(clock),
      .reset(reset),
      .we_i(accept && row_q == RW'(r)),
      .byte_idx_i(byte_q),
      .byte_i(in_byte),
      .row_o(rows[r])
    );
  end
  assign vec_out = rows[0];
  for (genvar r = 0; r < NUM_CLASSES; r++) begin : g_w
    assign weights_out[r] = rows[r+1];
  end
endmodule

// File: tb/tb_bnn_frame_loader.sv
// tb_bnn_frame_loader: directed + random frames checked against a byte-store model
module tb_bnn_frame_loader;
  localparam int NI = 196;
  localparam int NC = 10;
  localparam int BPR = 25;
  localparam int FB = 275;
  logic clock = 0;
  logic reset;
  logic [7:0] in_byte;
  logic in_valid, in_ready, frame_abort, out_valid, out_ack;
  logic [NI-1:0] vec_out;
  logic [NI-1:0] weights_out [NC-1:0];
  int passed = 0;
  int total = 0;
  logic [7:0] mem [FB];
  int pos = 0;
  bnn_frame_loader dut (
    .clock(clock),
    .reset(reset),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .frame_abort(frame_abort),
    .vec_out(vec_out),
    .weights_out(weights_out),
    .out_valid(out_valid),
    .out_ack(out_ack)
  );
  always #5 clock = ~clock;
  function automatic logic [NI-1:0] exp_row(int r);
    logic [NI-1:0] v = '0;
    for (int k = 0; k < BPR; k++) v = v | (NI'(mem[r*BPR+k]) << (8 * k));
    return v;
  endfunction
  function automatic logic [7:0] byte_for(int mode, int p);
    if (mode == 1) return (p / BPR == 0 || p / BPR == 5) ? 8'hFF : 8'h00;
    if (mode == 2) return p == 0 ? 8'h01 : p == 24 ? 8'hF8 : 8'h00;
    return 8'($urandom);
  endfunction
  task automatic chk(string tag, logic [NI-1:0] obs, logic [NI-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic chk_rows(string tag);
    chk({tag, "_vec"}, vec_out, exp_row(0));
    for (int r = 0; r < NC; r++) chk($sformatf("%s_w%0d", tag, r), weights_out[r], exp_row(r + 1));
  endtask
  task automatic send(logic [7:0] b);
    in_byte = b;
    in_valid = 1;
    @(posedge clock);
    #1;
    in_valid = 0;
    mem[pos] = b;
    pos = (pos + 1) % FB;
  endtask
  task automatic stream(int n, bit gaps, int mode);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_byte = 8'($urandom);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clock);
          #1;
        end
      end
      send(byte_for(mode, pos));
    end
  endtask
  task automatic ack();
    out_ack = 1;
    @(posedge clock);
    #1;
    out_ack = 0;
  endtask
  initial begin
    logic [NI-1:0] t3;
    for (int i = 0; i < FB; i++) mem[i] = 8'h00;
    reset = 0;
    in_valid = 0;
    in_byte = 0;
    frame_abort = 0;
    out_ack = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk_rows("rst");
    reset = 1;
    stream(FB, 0, 1);
    chk("t2_valid", out_valid, 1);
    chk("t2_ready", in_ready, 0);
    chk("t2_w4_ones", weights_out[4], '1);
    chk_rows("t2");
    #2 reset = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_vec", vec_out, '0);
    chk("arst_w4", weights_out[4], '0);
    for (int i = 0; i < FB; i++) mem[i] = 8'h00;
    pos = 0;
    @(posedge clock);
    #1;
    reset = 1;
    stream(FB, 0, 2);
    t3 = {4'b1000, 191'b0, 1'b1};
    chk("t3_vec_bits", vec_out, t3);
    chk_rows("t3");
    ack();
    chk("t3_ack_valid", out_valid, 0);
    stream(FB, 1, 0);
    chk("t4_valid", out_valid, 1);
    chk_rows("t4");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_byte = 8'($urandom);
      @(posedge clock);
      #1;
    end
    in_valid = 0;
    chk("t4_hold_valid", out_valid, 1);
    chk_rows("t4hold");
    ack();
    chk("t4_ack_valid", out_valid, 0);
    chk("t4_ack_ready", in_ready, 1);
    send(8'hA5);
    chk("t4_first_byte", vec_out[7:0], 8'hA5);
    chk_rows("t4first");
    stream(FB - 1, 0, 0);
    chk("t4_refill_valid", out_valid, 1);
    chk_rows("t4refill");
    ack();
    stream(30, 0, 0);
    in_byte = 8'h3C;
    in_valid = 1;
    frame_abort = 1;
    @(posedge clock);
    #1;
    frame_abort = 0;
    in_valid = 0;
    pos = 0;
    chk("t5_abort_valid", out_valid, 0);
    chk("t5_abort_ready", in_ready, 1);
    chk_rows("t5abort");
    stream(FB, 1, 0);
    chk("t5_valid", out_valid, 1);
    chk_rows("t5");
    ack();
    stream(100, 0, 0);
    ack();
    chk("t6_ack_valid", out_valid, 0);
    chk("t6_ack_ready", in_ready, 1);
    stream(FB - 101, 0, 0);
    chk("t6_not_yet", out_valid, 0);
    stream(1, 0, 0);
    chk("t6_valid", out_valid, 1);
    chk_rows("t6");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bnn_frame_loader.md
Name: bnn_frame_loader

Overview:
Byte-serial front end for the BNN output stage. It receives one activation vector and the ten class weight rows as an 8-bit valid/ready stream from the Tiny Tapeout input pins. It assembles them into the wide parallel vectors that final_layer_sequential consumes, then holds them stable under out_valid until the consumer acknowledges.

Parameters:
- NUM_INPUTS, 196, bits per row (flattened activation width).
- NUM_CLASSES, 10, number of weight rows (output classes).
- BYTE_W, 8, stream byte width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_byte  input  BYTE_W  stream data byte.
- in_valid  input  1  in_byte is valid this cycle.
- in_ready  output  1  loader can accept a byte this cycle.
- frame_abort  input  1  synchronous restart of the current frame.
- vec_out  output  NUM_INPUTS  assembled activation vector.
- weights_out  output  [NUM_INPUTS-1:0] x NUM_CLASSES (unpacked [NUM_CLASSES-1:0])  assembled weight rows.
- out_valid  output  1  complete frame held on vec_out/weights_out.
- out_ack  input  1  consumer has taken the frame.

Behaviour:
- Derived constants:
  - BYTES_PER_ROW = ceil(NUM_INPUTS/BYTE_W), which is 25.
  - ROWS = NUM_CLASSES+1, which is 11.
  - FRAME_BYTES = ROWS*BYTES_PER_ROW, which is 275.
- Frame order:
  - Row 0 is the activation vector (vec_out).
  - Row r, for r = 1..10, is weights_out[r-1].
  - Rows arrive strictly in order.
- Byte mapping: byte k of a row writes row bits [BYTE_W*k+BYTE_W-1 : BYTE_W*k]. Bit j of a row comes from bit (j mod 8) of byte (j div 8). In the last byte, bits that map to j >= NUM_INPUTS are discarded (upper 4 bits of byte 24).
- Counters:
  - byte_idx runs 0..BYTES_PER_ROW-1 (5 bits) and wraps to 0 after the last byte of a row.
  - row_idx runs 0..ROWS-1 (4 bits) and increments when byte_idx wraps.
- FSM has two states:
  - LOAD: in_ready=1. A byte is accepted on a rising edge with in_valid&&in_ready; the accepting edge writes the byte and advances the counters. When the accepted byte is row 10, byte 24, the same edge moves to FULL and sets out_valid=1. There is zero idle cycle between the last byte and out_valid.
  - FULL: in_ready=0 and out_valid=1. in_valid is ignored and all storage is frozen. If out_ack=1 on an edge in FULL, the next state is LOAD, out_valid=0 and both counters are 0. out_ack is ignored in LOAD.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ack.
- frame_abort (synchronous, sampled on edge):
  - Forces LOAD, counters to 0 and out_valid=0.
  - Takes priority over byte acceptance and out_ack on the same edge.
  - Stored row bits are not cleared.
- Storage is not cleared between frames; rows are overwritten as new bytes arrive.
- Reset (reset=0, asynchronous, immediate):
  - State=LOAD, counters=0, out_valid=0.
  - vec_out and all weights_out = 0.
  - in_ready reads 1 while in LOAD, including during reset.
- While out_valid=1, vec_out and weights_out do not change until out_ack or frame_abort is taken.

Decomposition:
- Shared package bnn_pkg holds:
  - NUM_INPUTS, NUM_CLASSES and BYTE_W defaults.
  - BYTES_PER_ROW and ROWS localparams.
  - loader_state_t enum {LOAD, FULL}.
- One sub-module, bnn_row_register: a single NUM_INPUTS-bit row with byte-index write enable and tail-bit masking. It is instantiated ROWS times, and each instance is selected by row_idx.

Test Plan:
1. Reset: hold reset=0 for 2 cycles -> out_valid=0, in_ready=1, vec_out=0, all weights_out=0. Assert reset mid-cycle -> outputs clear without a clock edge.
2. Full frame: stream 275 bytes with in_valid=1 continuously; rows 0 and 5 are all 0xFF, all other rows 0x00 -> out_valid=1 after the 275th accepting edge; vec_out all 196 ones; weights_out[4] all ones; other rows 0; in_ready=0. Feeding these outputs into final_layer_sequential gives answer=4.
3. Bit order/tail: row 0 byte 0=0x01, byte 24=0xF8, other bytes 0x00 -> vec_out[0]=1, vec_out[195:192]=4'b1000, all other bits 0.
4. Backpressure/hold: insert random in_valid=0 gaps -> the same final vectors as with no gaps. In FULL, hold in_valid=1 with new data for 5 cycles -> outputs unchanged. Pulse out_ack -> out_valid=0 on the next cycle and the next byte lands in row 0, byte 0.
5. Abort: after 30 bytes, assert frame_abort with in_valid=1 on the same edge -> that byte is not accepted. Counters restart, so a following full 275-byte frame completes correctly.
6. Ack outside FULL: pulse out_ack during LOAD -> no state change and the byte count is unaffected.
